conv_operand_tx: RTL and testbench
==================================

# conv_operand_tx

Streams activation (a) and weight (b) operands into the conv controller's a/b valid/ready handshake, in the controller's loop order: x, y, ch_in, ch_out, k_v, k_h (k_h innermost). It reads from an activation memory and a weight memory, each with 1-cycle read latency. Zero-padded taps are produced without a memory read. A 2-entry skid FIFO keeps throughput at one beat/cycle under backpressure. It sits on the host/input side, opposite the controller FSM.

## Interface
- FEATURE_MAP_WIDTH, 1024: W.
- FEATURE_MAP_HEIGHT, 1024: H.
- INPUT_NB_CHANNELS, 64: CIN.
- OUTPUT_NB_CHANNELS, 64: COUT.
- KERNEL_SIZE, 3: K, odd.
- DATA_WIDTH, 16: operand width.
- ACT_ADDR_WIDTH, 20: activation memory address width.
- WGT_ADDR_WIDTH, 16: weight memory address width.
- clk  in  1  clock.
- arst_n_in  in  1  reset, asynchronous, active-low.
- start  in  1  begin stream; ignored unless IDLE.
- busy  out  1  high from the cycle after start until the last beat transfers.
- done  out  1  one-cycle pulse, registered, the cycle after the last beat transfers.
- act_re  out  1  activation read enable.
- act_addr  out  ACT_ADDR_WIDTH  activation read address.
- act_rdata  in  DATA_WIDTH  valid 1 cycle after act_re.
- wgt_re  out  1  weight read enable.
- wgt_addr  out  WGT_ADDR_WIDTH  weight read address.
- wgt_rdata  in  DATA_WIDTH  valid 1 cycle after wgt_re.
- a_valid, b_valid  out  1  always equal; an operand pair is presented.
- a_ready, b_ready  in  1  consumer readiness.
- a_data, b_data  out  DATA_WIDTH  operand pair.

## Operation
- FSM has three states:
  - IDLE: start moves to ISSUE.
  - ISSUE: issues one read slot per cycle while space allows; the last slot moves to DRAIN.
  - DRAIN: waits for the FIFO to empty and no read to be in flight, then returns to IDLE and pulses done.
- Transfer rule: a pair transfers when a_valid && a_ready && b_ready. a_valid/b_valid stay high with data stable until that transfer; they never drop without a transfer.
- Slot issue condition: fifo_count + inflight < 2, where inflight is a registered 1-bit count of a slot issued last cycle. A pop in the same cycle counts as freeing space.
- Per slot:
  - xs = x + k_h − K/2; ys = y + k_v − K/2, signed.
  - pad = xs<0 || xs≥W || ys<0 || ys≥H.
  - act_addr = (ys·W + xs)·CIN + ch_in.
  - act_re = !pad; when pad, act_addr = 0.
  - wgt_addr = ((ch_out·CIN + ch_in)·K + k_v)·K + k_h; wgt_re = 1.
- Response stage: the pad flag is delayed one cycle. The FIFO writes {pad ? 0 : act_rdata, wgt_rdata}.
- Total beats N = W·H·CIN·COUT·K·K. Counters wrap innermost-first exactly as the loop order; each wrap resets to 0.
- Addresses are computed full-width, then truncated to ACT_ADDR_WIDTH / WGT_ADDR_WIDTH.

## Timing
- Reset values: FSM IDLE, all counters 0, FIFO empty, inflight 0. Outputs busy, done, act_re, wgt_re, a_valid, b_valid, all addresses and data are 0.
- Latency:
  - start sampled at edge 0.
  - First slot issued in cycle 1 (act_re/wgt_re high).
  - a_valid high in cycle 2.
  - With ready held high: one transfer per cycle; last transfer in cycle N+1; done in cycle N+2; busy low in cycle N+2.
- Backpressure: when ready is low, at most 2 entries are buffered and no slot issues once count + inflight = 2. On ready re-assertion, throughput resumes at 1/cycle with no bubble.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- start while busy is ignored. start in the same cycle as done is accepted (IDLE is entered on that edge).
- Reset mid-stream: immediate return to IDLE, FIFO flushed, valid low, no done pulse.

## Structure
- Shared package conv_pkg holds the fsm state enum (IDLE, ISSUE, DRAIN) for this block and a pad_offset function returning K/2.
- One sub-module: operand_skid_fifo. It is 2 entries of 2·DATA_WIDTH, with push, pop, count, and full/empty flags.
- Counters use the existing REG macro.

## Test plan
- Config W=H=3, CIN=COUT=2, K=3, memories act[i]=i+1 and wgt[i]=100+i, ready held high:
  - 324 beats.
  - First pair (x=y=0, k_v=k_h=0) = (0,100), padded.
  - Fifth pair (k_v=1, k_h=1) = (act[0]+... → 1, 104).
  - done at cycle 326.
- Same config, ready toggled 1-0 every cycle: all 324 pairs match the golden model in order, a_data stable while ready is low, never more than 2 reads outstanding.
- Ready held low 10 cycles after first valid: exactly 2 reads issued, then act_re=wgt_re=0. On release, a transfer every cycle.
- K=1, W=H=1, CIN=COUT=1: a single beat (act[0], wgt[0]). done 3 cycles after start. No pad.
- Reset asserted at beat 50: all outputs 0 asynchronously. A new start produces the full stream from the first pair again.
- start pulsed while busy: no effect on the stream or the beat count.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg
// Shared state encoding, kernel helper and register macro for the conv slice.
// Revision: 1.0
// ============================================================================
`ifndef CONV_PKG_REG_MACRO
`define CONV_PKG_REG_MACRO
`define REG(clk_, rst_n_, q_, d_, rst_val_) \
  always_ff @(posedge clk_ or negedge rst_n_) \
    if (!rst_n_) q_ <= rst_val_; \
    else q_ <= d_;
`endif

package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fsm_state_e;

  function automatic int pad_offset(input int k);
    return k / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_skid_fifo.sv
`default_nettype none
// ============================================================================
// operand_skid_fifo
// Two-entry FIFO holding operand pairs; push and pop may coincide when full.
// Revision: 1.0
// ============================================================================
module operand_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && (r_count != 2'd0);
  assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

  for (genvar i = 0; i < 2; i++) begin : g_entry
    always_ff @(posedge clk or negedge arst_n_in)
      if (!arst_n_in) r_mem[i] <= '0;
      else if (w_do_push && (int'(r_wr_ptr) == i)) r_mem[i] <= wdata;
  end

  `REG(clk, arst_n_in, r_wr_ptr, r_wr_ptr ^ w_do_push, 1'b0)
  `REG(clk, arst_n_in, r_rd_ptr, r_rd_ptr ^ w_do_pop, 1'b0)
  `REG(clk, arst_n_in, r_count, r_count + {1'b0, w_do_push} - {1'b0, w_do_pop}, 2'd0)

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/conv_operand_tx.sv
`default_nettype none
// ============================================================================
// conv_operand_tx
// Streams zero-padded activation/weight operand pairs in conv loop order.
// Revision: 1.0
// ============================================================================
module conv_operand_tx
  import conv_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3,
  parameter int DATA_WIDTH         = 16,
  parameter int ACT_ADDR_WIDTH     = 20,
  parameter int WGT_ADDR_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      act_re,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  input  logic [DATA_WIDTH-1:0]     act_rdata,
  output logic                      wgt_re,
  output logic [WGT_ADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0]     wgt_rdata,
  output logic                      a_valid,
  output logic                      b_valid,
  input  logic                      a_ready,
  input  logic                      b_ready,
  output logic [DATA_WIDTH-1:0]     a_data,
  output logic [DATA_WIDTH-1:0]     b_data
);

  localparam int c_pad = pad_offset(KERNEL_SIZE);
  localparam int c_xw  = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1;
  localparam int c_yw  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int c_ciw = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam int c_cow = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int c_kw  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int c_fw  = 2 * DATA_WIDTH;

  fsm_state_e      r_state, w_state_nxt;
  logic [c_xw-1:0]  r_x, w_x_nxt;
  logic [c_yw-1:0]  r_y, w_y_nxt;
  logic [c_ciw-1:0] r_ci, w_ci_nxt;
  logic [c_cow-1:0] r_co, w_co_nxt;
  logic [c_kw-1:0]  r_kv, w_kv_nxt;
  logic [c_kw-1:0]  r_kh, w_kh_nxt;
  logic w_x_last, w_y_last, w_ci_last, w_co_last, w_kv_last, w_kh_last, w_last_slot;
  logic w_in_issue, w_in_drain, w_issue, w_pop, w_last_xfer, w_pad;
  logic r_inflight, r_pad_d, r_done;
  logic [2:0] w_occ;
  int   w_xs, w_ys, w_act_full, w_wgt_full;
  logic [1:0]            w_fifo_count;
  logic                  w_fifo_full, w_fifo_empty, w_fifo_push, w_fifo_pop;
  logic [DATA_WIDTH-1:0] w_act_resp;
  logic [c_fw-1:0]       w_resp, w_fifo_rdata, w_head;

  always_ff @(posedge clk or negedge arst_n_in)
    if (!arst_n_in) r_state <= IDLE;
    else            r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = ISSUE;
      ISSUE:   if (w_issue && w_last_slot) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != IDLE);
    w_in_issue = (r_state == ISSUE);
    w_in_drain = (r_state == DRAIN);
  end

  // Occupancy counts the slot in flight; a pop this cycle already frees space.
  assign w_occ       = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_pop       = a_valid && a_ready && b_ready;
  assign w_issue     = w_in_issue && ((w_occ - {2'b00, w_pop}) < 3'd2);
  assign w_last_xfer = w_in_drain && w_pop && (w_occ == 3'd1);

  always_comb begin
    w_kh_last   = (r_kh == c_kw'(KERNEL_SIZE - 1));
    w_kv_last   = (r_kv == c_kw'(KERNEL_SIZE - 1));
    w_co_last   = (r_co == c_cow'(OUTPUT_NB_CHANNELS - 1));
    w_ci_last   = (r_ci == c_ciw'(INPUT_NB_CHANNELS - 1));
    w_y_last    = (r_y == c_yw'(FEATURE_MAP_HEIGHT - 1));
    w_x_last    = (r_x == c_xw'(FEATURE_MAP_WIDTH - 1));
    w_last_slot = w_kh_last && w_kv_last && w_co_last && w_ci_last && w_y_last && w_x_last;
    w_kh_nxt = r_kh;
    w_kv_nxt = r_kv;
    w_co_nxt = r_co;
    w_ci_nxt = r_ci;
    w_y_nxt  = r_y;
    w_x_nxt  = r_x;
    if (w_issue) begin
      w_kh_nxt = w_kh_last ? '0 : r_kh + c_kw'(1);
      if (w_kh_last) begin
        w_kv_nxt = w_kv_last ? '0 : r_kv + c_kw'(1);
        if (w_kv_last) begin
          w_co_nxt = w_co_last ? '0 : r_co + c_cow'(1);
          if (w_co_last) begin
            w_ci_nxt = w_ci_last ? '0 : r_ci + c_ciw'(1);
            if (w_ci_last) begin
              w_y_nxt = w_y_last ? '0 : r_y + c_yw'(1);
              if (w_y_last) w_x_nxt = w_x_last ? '0 : r_x + c_xw'(1);
            end
          end
        end
      end
    end
  end

  `REG(clk, arst_n_in, r_kh, w_kh_nxt, '0)
  `REG(clk, arst_n_in, r_kv, w_kv_nxt, '0)
  `REG(clk, arst_n_in, r_co, w_co_nxt, '0)
  `REG(clk, arst_n_in, r_ci, w_ci_nxt, '0)
  `REG(clk, arst_n_in, r_y, w_y_nxt, '0)
  `REG(clk, arst_n_in, r_x, w_x_nxt, '0)

  always_comb begin
    w_xs       = int'(r_x) + int'(r_kh) - c_pad;
    w_ys       = int'(r_y) + int'(r_kv) - c_pad;
    w_pad      = (w_xs < 0) || (w_xs >= FEATURE_MAP_WIDTH) ||
                 (w_ys < 0) || (w_ys >= FEATURE_MAP_HEIGHT);
    w_act_full = (w_ys * FEATURE_MAP_WIDTH + w_xs) * INPUT_NB_CHANNELS + int'(r_ci);
    w_wgt_full = ((int'(r_co) * INPUT_NB_CHANNELS + int'(r_ci)) * KERNEL_SIZE
                  + int'(r_kv)) * KERNEL_SIZE + int'(r_kh);
    act_re     = w_issue && !w_pad;
    act_addr   = act_re ? ACT_ADDR_WIDTH'(w_act_full) : '0;
    wgt_re     = w_issue;
    wgt_addr   = w_issue ? WGT_ADDR_WIDTH'(w_wgt_full) : '0;
  end

  `REG(clk, arst_n_in, r_inflight, w_issue, 1'b0)
  `REG(clk, arst_n_in, r_pad_d, w_issue && w_pad, 1'b0)
  `REG(clk, arst_n_in, r_done, w_last_xfer, 1'b0)

  assign w_act_resp = r_pad_d ? '0 : act_rdata;
  assign w_resp     = {w_act_resp, wgt_rdata};

  // An empty FIFO lets the read response go straight out; it is only
  // captured when the consumer does not take it in the same cycle.
  assign a_valid     = !w_fifo_empty || r_inflight;
  assign b_valid     = a_valid;
  assign w_fifo_pop  = w_pop && !w_fifo_empty;
  assign w_fifo_push = r_inflight && !(w_fifo_empty && w_pop) && !(w_fifo_full && !w_fifo_pop);
  assign w_head      = !w_fifo_empty ? w_fifo_rdata : (r_inflight ? w_resp : '0);
  assign a_data      = w_head[c_fw-1:DATA_WIDTH];
  assign b_data      = w_head[DATA_WIDTH-1:0];
  assign done        = r_done;

  operand_skid_fifo #(
    .WIDTH (c_fw)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (w_fifo_push),
    .pop       (w_fifo_pop),
    .wdata     (w_resp),
    .rdata     (w_fifo_rdata),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_operand_tx.sv
`default_nettype none
// ============================================================================
// tb_conv_operand_tx
// Directed bench: 3x3x2x2 K=3 stream and a 1x1x1x1 K=1 single-beat stream.
// Revision: 1.0
// ============================================================================
module tb_conv_operand_tx;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        s_start = 1'b0, s_ready = 1'b0;
  logic        s_busy, s_done, s_act_re, s_wgt_re, s_a_valid, s_b_valid;
  logic [19:0] s_act_addr;
  logic [15:0] s_wgt_addr, s_a_data, s_b_data;
  logic [15:0] s_act_rdata = '0, s_wgt_rdata = '0;
  logic [15:0] s_act_mem [18];
  logic [15:0] s_wgt_mem [36];

  logic        t_start = 1'b0, t_ready = 1'b0;
  logic        t_busy, t_done, t_act_re, t_wgt_re, t_a_valid, t_b_valid;
  logic [19:0] t_act_addr;
  logic [15:0] t_wgt_addr, t_a_data, t_b_data;
  logic [15:0] t_act_rdata = '0, t_wgt_rdata = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_act_re) s_act_rdata <= s_act_mem[s_act_addr[4:0]];
    if (s_wgt_re) s_wgt_rdata <= s_wgt_mem[s_wgt_addr[5:0]];
    if (t_act_re) t_act_rdata <= 16'd1;
    if (t_wgt_re) t_wgt_rdata <= 16'd100;
  end

  conv_operand_tx #(
    .FEATURE_MAP_WIDTH(3), .FEATURE_MAP_HEIGHT(3), .INPUT_NB_CHANNELS(2),
    .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3), .DATA_WIDTH(16),
    .ACT_ADDR_WIDTH(20), .WGT_ADDR_WIDTH(16)
  ) dut_s (
    .clk(clk), .arst_n_in(arst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .act_re(s_act_re), .act_addr(s_act_addr), .act_rdata(s_act_rdata),
    .wgt_re(s_wgt_re), .wgt_addr(s_wgt_addr), .wgt_rdata(s_wgt_rdata),
    .a_valid(s_a_valid), .b_valid(s_b_valid), .a_ready(s_ready), .b_ready(s_ready),
    .a_data(s_a_data), .b_data(s_b_data)
  );

  conv_operand_tx #(
    .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1), .INPUT_NB_CHANNELS(1),
    .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(1), .DATA_WIDTH(16),
    .ACT_ADDR_WIDTH(20), .WGT_ADDR_WIDTH(16)
  ) dut_t (
    .clk(clk), .arst_n_in(arst_n), .start(t_start), .busy(t_busy), .done(t_done),
    .act_re(t_act_re), .act_addr(t_act_addr), .act_rdata(t_act_rdata),
    .wgt_re(t_wgt_re), .wgt_addr(t_wgt_addr), .wgt_rdata(t_wgt_rdata),
    .a_valid(t_a_valid), .b_valid(t_b_valid), .a_ready(t_ready), .b_ready(t_ready),
    .a_data(t_a_data), .b_data(t_b_data)
  );

  // Expected pair for beat n of the 3x3, CIN=COUT=2, K=3 stream.
  function automatic logic [31:0] gold(input int n);
    int kh, kv, co, ci, y, x, xs, ys;
    logic [15:0] av, bv;
    kh = n % 3; kv = (n / 3) % 3; co = (n / 9) % 2;
    ci = (n / 18) % 2; y = (n / 36) % 3; x = n / 108;
    xs = x + kh - 1; ys = y + kv - 1;
    if (xs < 0 || xs >= 3 || ys < 0 || ys >= 3) av = 16'd0;
    else av = 16'((ys * 3 + xs) * 2 + ci + 1);
    bv = 16'(100 + ((co * 2 + ci) * 3 + kv) * 3 + kh);
    return {av, bv};
  endfunction

  task automatic test_reset;
    n_checks++;
    if ({s_busy, s_done, s_act_re, s_wgt_re, s_a_valid, s_b_valid, s_act_addr,
         s_wgt_addr, s_a_data, s_b_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%b done=%b act_re=%b wgt_re=%b valid=%b addr=%h/%h data=%h/%h required all 0",
               s_busy, s_done, s_act_re, s_wgt_re, s_a_valid, s_act_addr, s_wgt_addr, s_a_data, s_b_data);
    end
  endtask

  task automatic test_full_stream(input bit pulse_start);
    int cyc, beat, done_cyc;
    logic [31:0] exp;
    cyc = 0; beat = 0; done_cyc = -1;
    @(posedge clk); #1; s_start = 1'b1; s_ready = 1'b1;
    while (done_cyc < 0 && cyc < 400) begin
      @(posedge clk); cyc++; #1;
      s_start = pulse_start && (cyc == 50 || cyc == 100 || cyc == 325);
      #1;
      if (cyc == 1) begin
        n_checks++;
        if ({s_act_re, s_wgt_re, s_a_valid, s_busy} !== 4'b0101) begin
          n_errors++;
          $display("FAIL first_slot: act_re,wgt_re,a_valid,busy=%b required 0101",
                   {s_act_re, s_wgt_re, s_a_valid, s_busy});
        end
      end
      if (cyc == 2) begin
        n_checks++;
        if (s_a_valid !== 1'b1 || s_b_valid !== 1'b1) begin
          n_errors++;
          $display("FAIL first_valid: a_valid=%b b_valid=%b required 1", s_a_valid, s_b_valid);
        end
      end
      if (s_a_valid && s_ready) begin
        exp = gold(beat);
        if (beat == 0) exp = {16'd0, 16'd100};
        if (beat == 4) exp = {16'd1, 16'd104};
        n_checks++;
        if ({s_a_data, s_b_data} !== exp) begin
          n_errors++;
          $display("FAIL stream_beat%0d: a/b=%0d/%0d required %0d/%0d",
                   beat, s_a_data, s_b_data, exp[31:16], exp[15:0]);
        end
        beat++;
      end
      if (s_done) begin
        done_cyc = cyc;
        n_checks++;
        if (s_busy !== 1'b0) begin
          n_errors++;
          $display("FAIL busy_at_done: busy=%b required 0", s_busy);
        end
      end
    end
    n_checks++;
    if (beat != 324) begin
      n_errors++;
      $display("FAIL stream_beats: got %0d required 324", beat);
    end
    n_checks++;
    if (done_cyc != 326) begin
      n_errors++;
      $display("FAIL done_cycle: got %0d required 326", done_cyc);
    end
    @(posedge clk); #1; s_start = 1'b0; #1;
    @(posedge clk); #2;
    n_checks++;
    if (s_busy !== 1'b0 || s_wgt_re !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_done: busy=%b wgt_re=%b required 0/0", s_busy, s_wgt_re);
    end
  endtask

  task automatic test_toggle_ready;
    int cyc, beat, issued, max_out;
    bit finished, prev_hold;
    logic [31:0] prev_data;
    cyc = 0; beat = 0; issued = 0; max_out = 0; finished = 0; prev_hold = 0; prev_data = '0;
    @(posedge clk); #1; s_start = 1'b1; s_ready = 1'b1;
    while (!finished && cyc < 1000) begin
      @(posedge clk); cyc++; #1;
      s_start = 1'b0; s_ready = (cyc % 2 == 1);
      #1;
      if (prev_hold) begin
        n_checks++;
        if (s_a_valid !== 1'b1 || {s_a_data, s_b_data} !== prev_data) begin
          n_errors++;
          $display("FAIL hold_stable: valid=%b data=%h required 1 %h", s_a_valid, {s_a_data, s_b_data}, prev_data);
        end
      end
      if (s_wgt_re) issued++;
      if (s_a_valid && s_ready) begin
        n_checks++;
        if ({s_a_data, s_b_data} !== gold(beat)) begin
          n_errors++;
          $display("FAIL toggle_beat%0d: a/b=%h required %h", beat, {s_a_data, s_b_data}, gold(beat));
        end
        beat++;
      end
      if (issued - beat > max_out) max_out = issued - beat;
      prev_hold = s_a_valid && !s_ready;
      prev_data = {s_a_data, s_b_data};
      if (s_done) finished = 1;
    end
    n_checks++;
    if (beat != 324 || !finished) begin
      n_errors++;
      $display("FAIL toggle_beats: got %0d done=%b required 324 done=1", beat, finished);
    end
    n_checks++;
    if (max_out > 2) begin
      n_errors++;
      $display("FAIL outstanding: got %0d required <=2", max_out);
    end
  endtask

  task automatic test_backpressure;
    int cyc, beat, issued, bubbles, done_cyc;
    cyc = 0; beat = 0; issued = 0; bubbles = 0; done_cyc = -1;
    @(posedge clk); #1; s_start = 1'b1; s_ready = 1'b0;
    while (done_cyc < 0 && cyc < 500) begin
      @(posedge clk); cyc++; #1;
      s_start = 1'b0; s_ready = (cyc >= 12);
      #1;
      if (cyc < 12 && s_wgt_re) issued++;
      if (cyc == 11) begin
        n_checks++;
        if (issued != 2 || s_act_re !== 1'b0 || s_wgt_re !== 1'b0 || s_a_valid !== 1'b1) begin
          n_errors++;
          $display("FAIL stall_reads: issued=%0d act_re=%b wgt_re=%b valid=%b required 2 0 0 1",
                   issued, s_act_re, s_wgt_re, s_a_valid);
        end
      end
      if (cyc >= 12 && !s_a_valid && !s_done) bubbles++;
      if (s_a_valid && s_ready) begin
        n_checks++;
        if ({s_a_data, s_b_data} !== gold(beat)) begin
          n_errors++;
          $display("FAIL bp_beat%0d: a/b=%h required %h", beat, {s_a_data, s_b_data}, gold(beat));
        end
        beat++;
      end
      if (s_done) done_cyc = cyc;
    end
    n_checks++;
    if (bubbles != 0 || beat != 324) begin
      n_errors++;
      $display("FAIL bp_resume: bubbles=%0d beats=%0d required 0 324", bubbles, beat);
    end
    n_checks++;
    if (done_cyc != 336) begin
      n_errors++;
      $display("FAIL bp_done_cycle: got %0d required 336", done_cyc);
    end
  endtask

  task automatic test_single_beat;
    int beats, ndone, d0, d1;
    beats = 0; ndone = 0; d0 = -1; d1 = -1;
    @(posedge clk); #1; t_start = 1'b1; t_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1; t_start = (c == 3); #1;
      if (c == 1) begin
        n_checks++;
        if ({t_act_re, t_wgt_re, t_act_addr, t_wgt_addr} !== {2'b11, 36'd0}) begin
          n_errors++;
          $display("FAIL single_issue: act_re=%b wgt_re=%b addr=%h/%h required 1 1 0 0",
                   t_act_re, t_wgt_re, t_act_addr, t_wgt_addr);
        end
      end
      if (t_a_valid && t_ready) begin
        n_checks++;
        if ({t_a_data, t_b_data} !== {16'd1, 16'd100}) begin
          n_errors++;
          $display("FAIL single_data: a/b=%0d/%0d required 1/100", t_a_data, t_b_data);
        end
        beats++;
      end
      if (t_done) begin
        if (ndone == 0) d0 = c; else d1 = c;
        ndone++;
      end
    end
    n_checks++;
    if (beats != 2 || ndone != 2) begin
      n_errors++;
      $display("FAIL single_counts: beats=%0d dones=%0d required 2 2", beats, ndone);
    end
    n_checks++;
    if (d0 != 3 || d1 != 6) begin
      n_errors++;
      $display("FAIL single_done_cycles: got %0d,%0d required 3,6", d0, d1);
    end
  endtask

  task automatic test_reset_mid_stream;
    int cyc, beat;
    cyc = 0; beat = 0;
    @(posedge clk); #1; s_start = 1'b1; s_ready = 1'b1;
    while (beat < 50 && cyc < 200) begin
      @(posedge clk); cyc++; #1; s_start = 1'b0; #1;
      if (s_a_valid && s_ready) beat++;
    end
    #1; arst_n = 1'b0; #1;
    n_checks++;
    if (beat != 50 || {s_busy, s_done, s_act_re, s_wgt_re, s_a_valid, s_b_valid,
                       s_act_addr, s_wgt_addr, s_a_data, s_b_data} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: beat=%0d busy=%b valid=%b re=%b%b data=%h/%h required 50 and all 0",
               beat, s_busy, s_a_valid, s_act_re, s_wgt_re, s_a_data, s_b_data);
    end
    @(posedge clk); @(negedge clk); arst_n = 1'b1;
    test_full_stream(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 18; i++) s_act_mem[i] = 16'(i + 1);
    for (int i = 0; i < 36; i++) s_wgt_mem[i] = 16'(100 + i);
    #12;
    test_reset();
    @(negedge clk); arst_n = 1'b1;
    test_full_stream(1'b0);
    test_toggle_ready();
    test_backpressure();
    test_single_beat();
    test_reset_mid_stream();
    test_full_stream(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
